// File: rtl/bypass_responder.sv
// bypass_responder: uncached bypass responder with an in-order tracking FIFO and misalignment error responses
module bypass_responder #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int ID_WIDTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_i,
   input  logic                we_i,
   input  logic [63:0]         addr_i,
   input  logic [63:0]         wdata_i,
   input  logic [7:0]          be_i,
   input  logic [1:0]          size_i,
   input  logic [ID_WIDTH-1:0] id_i,
   output logic                gnt_o,
   output logic                valid_o,
   output logic [63:0]         rdata_o,
   output logic [ID_WIDTH-1:0] id_o,
   output logic                err_o,
   output logic                mem_req_o,
   input  logic                mem_gnt_i,
   output logic                mem_we_o,
   output logic [63:0]         mem_wdata_o,
   output logic [7:0]          mem_be_o,
   output logic [63:0]         mem_addr_o,
   input  logic                mem_rvalid_i,
   input  logic [63:0]         mem_rdata_i,
   input  logic                mem_err_i
);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LAST = PW'(MAX_OUTSTANDING - 1);
   logic [CW-1:0]       r_cnt;
   logic [PW-1:0]       r_wptr, r_rptr;
   logic [ID_WIDTH-1:0] r_id_q [MAX_OUTSTANDING];
   logic [7:0]          r_be_q [MAX_OUTSTANDING];
   logic                r_we_q [MAX_OUTSTANDING];
   logic                r_err_pend;
   logic [ID_WIDTH-1:0] r_err_id;
   logic                r_valid, r_err;
   logic [63:0]         r_rdata;
   logic [ID_WIDTH-1:0] r_id;
   logic                w_aligned, w_full, w_empty, w_push, w_pop, w_mis_gnt;
   logic [63:0]         w_mask;
   assign w_aligned = size_i == 2'd0 ? 1'b1 :
                      size_i == 2'd1 ? ~addr_i[0] :
                      size_i == 2'd2 ? addr_i[1:0] == 2'b00 : addr_i[2:0] == 3'b000;
   assign w_full    = r_cnt == MAX_CNT;
   assign w_empty   = r_cnt == '0;
   assign mem_req_o = req_i & w_aligned & ~w_full;
   assign w_push    = mem_req_o & mem_gnt_i;
   assign w_pop     = mem_rvalid_i & ~w_empty;
   // misaligned requests wait for an empty FIFO so their error stays in grant order
   assign w_mis_gnt = req_i & ~w_aligned & w_empty & ~r_err_pend;
   assign gnt_o     = w_push | w_mis_gnt;
   assign mem_we_o    = we_i;
   assign mem_wdata_o = wdata_i;
   assign mem_be_o    = be_i;
   assign mem_addr_o  = {addr_i[63:3], 3'b000};
   for (genvar i = 0; i < 8; i++) begin : g_mask
      assign w_mask[8*i +: 8] = {8{r_be_q[r_rptr][i]}};
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt      <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_err_pend <= 1'b0;
         r_err_id   <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_rdata    <= '0;
         r_id       <= '0;
      end else begin
         r_cnt      <= r_cnt + CW'(w_push) - CW'(w_pop);
         if (w_push) r_wptr <= r_wptr == LAST ? '0 : r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr == LAST ? '0 : r_rptr + 1'b1;
         r_err_pend <= w_mis_gnt;
         if (w_mis_gnt) r_err_id <= id_i;
         r_valid    <= w_pop | r_err_pend;
         r_err      <= w_pop ? mem_err_i : r_err_pend;
         r_id       <= w_pop ? r_id_q[r_rptr] : r_err_pend ? r_err_id : '0;
         r_rdata    <= w_pop && !r_we_q[r_rptr] ? mem_rdata_i & w_mask : '0;
      end
   end
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_id_q[r_wptr] <= id_i;
         r_be_q[r_wptr] <= be_i;
         r_we_q[r_wptr] <= we_i;
      end
   end
   assign valid_o = r_valid;
   assign err_o   = r_err;
   assign rdata_o = r_rdata;
   assign id_o    = r_id;
   a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i) !(mem_rvalid_i && w_empty));
endmodule
